// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop sync, per-button debounce, left/right owner arbiter, press/release pulses.
// Optional auto-repeat of the owned direction is compiled in with `BTN_AUTO_REPEAT_EN.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic       character_clk,
  input  logic       sys_rst_n,
  input  logic       raw_left,
  input  logic       raw_right,
  input  logic       raw_jump,
  output logic       left_btn,
  output logic       right_btn,
  output logic       jump_btn,
  output logic       left_press,
  output logic       right_press,
  output logic       jump_press,
  output logic       jump_release,
  output logic [1:0] dbg_owner
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int BL = 0;
  localparam int BR = 1;
  localparam int BJ = 2;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_LEFT  = 2'd1,
    OWN_RIGHT = 2'd2
  } owner_t;

  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  owner_t        owner_q, owner_d;
  logic          gap;
  logic          left_press_q, left_press_d;
  logic          right_press_q, right_press_d;
  logic          jump_press_q, jump_press_d;
  logic          jump_prev_q;
  logic          jump_release_q, jump_release_d;

  assign raw = {raw_jump, raw_right, raw_left};

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // The flip happens on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = ~stable_q[i];
        else                      cnt_d[i]    = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) owner_q <= OWN_NONE;
    else            owner_q <= owner_d;
  end

  // Owner follows the next debounced level so the level output lines up with the
  // debounce flip; testing the level (not the edge) in NONE also hands over to a
  // direction that is still held when the other one is released.
  always_comb begin
    owner_d = owner_q;
    case (owner_q)
      OWN_NONE: begin
        if (stable_d[BL])      owner_d = OWN_LEFT;
        else if (stable_d[BR]) owner_d = OWN_RIGHT;
      end
      OWN_LEFT:  if (!stable_d[BL]) owner_d = OWN_NONE;
      OWN_RIGHT: if (!stable_d[BR]) owner_d = OWN_NONE;
      default:   owner_d = OWN_NONE;
    endcase
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
  // Reload so the next fire lands REPEAT_PERIOD cycles later; needs REPEAT_PERIOD <= REPEAT_DELAY.
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RW-1:0] rpt_q, rpt_d;
  logic          gap_q, gap_d;

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rpt_q <= '0;
      gap_q <= 1'b0;
    end else begin
      rpt_q <= rpt_d;
      gap_q <= gap_d;
    end
  end

  always_comb begin
    rpt_d = '0;
    gap_d = 1'b0;
    if (owner_q != OWN_NONE && owner_d == owner_q) begin
      if (rpt_q == RPT_FIRE) begin
        gap_d = 1'b1;
        rpt_d = RPT_RELOAD;
      end else begin
        rpt_d = rpt_q + 1'b1;
      end
    end
  end

  assign gap = gap_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
  assign gap = 1'b0;
`endif

  // A press pulse accompanies every rising edge of a level output, including the one after a gap.
  always_comb begin
    left_press_d   = (owner_d == OWN_LEFT)  && ((owner_q != OWN_LEFT)  || gap);
    right_press_d  = (owner_d == OWN_RIGHT) && ((owner_q != OWN_RIGHT) || gap);
    jump_press_d   = stable_d[BJ] & ~stable_q[BJ];
    jump_release_d = jump_prev_q & ~stable_q[BJ];
  end

  always_ff @(posedge character_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      left_press_q   <= 1'b0;
      right_press_q  <= 1'b0;
      jump_press_q   <= 1'b0;
      jump_prev_q    <= 1'b0;
      jump_release_q <= 1'b0;
    end else begin
      left_press_q   <= left_press_d;
      right_press_q  <= right_press_d;
      jump_press_q   <= jump_press_d;
      jump_prev_q    <= stable_q[BJ];
      jump_release_q <= jump_release_d;
    end
  end

  assign left_btn     = (owner_q == OWN_LEFT)  && !gap;
  assign right_btn    = (owner_q == OWN_RIGHT) && !gap;
  assign jump_btn     = stable_q[BJ];
  assign left_press   = left_press_q;
  assign right_press  = right_press_q;
  assign jump_press   = jump_press_q;
  assign jump_release = jump_release_q;
  assign dbg_owner    = owner_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: the driver pushes hand-timed expected output
// vectors per clock edge; a negedge monitor pops and compares them.
module tb_btn_conditioner;

  localparam int W = 9;
  // Vector layout: {left_btn, right_btn, jump_btn, left_press, right_press, jump_press, jump_release, owner[1:0]}
  localparam logic [W-1:0] ZV = 9'b000_0000_00;
  localparam logic [W-1:0] LH = 9'b100_0000_01;
  localparam logic [W-1:0] LP = 9'b100_1000_01;
  localparam logic [W-1:0] LG = 9'b000_0000_01;
  localparam logic [W-1:0] RH = 9'b010_0000_10;
  localparam logic [W-1:0] RP = 9'b010_0100_10;
  localparam logic [W-1:0] JH = 9'b001_0000_00;
  localparam logic [W-1:0] JP = 9'b001_0010_00;
  localparam logic [W-1:0] JR = 9'b000_0001_00;

  logic       character_clk = 1'b0;
  logic       sys_rst_n;
  logic       raw_left, raw_right, raw_jump;
  logic       left_btn, right_btn, jump_btn;
  logic       left_press, right_press, jump_press, jump_release;
  logic [1:0] dbg_owner;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  string        tag;
  logic [W-1:0] mon_exp, mon_act;
  string        mon_tag;
  int           n_vec = 0;
  int           n_err = 0;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (16),
    .REPEAT_PERIOD  (4)
  ) dut (
    .character_clk(character_clk),
    .sys_rst_n    (sys_rst_n),
    .raw_left     (raw_left),
    .raw_right    (raw_right),
    .raw_jump     (raw_jump),
    .left_btn     (left_btn),
    .right_btn    (right_btn),
    .jump_btn     (jump_btn),
    .left_press   (left_press),
    .right_press  (right_press),
    .jump_press   (jump_press),
    .jump_release (jump_release),
    .dbg_owner    (dbg_owner)
  );

  // Clock / watchdog
  always #5 character_clk = ~character_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors pending", exp_q.size());
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

  // Driver: raw levels before an edge, expected outputs after that edge
  task automatic seg(input int n, input logic l, input logic r, input logic j, input logic [W-1:0] e);
    for (int k = 0; k < n; k++) begin
      raw_left  = l;
      raw_right = r;
      raw_jump  = j;
      @(posedge character_clk);
      #1;
      exp_q.push_back(e);
      tag_q.push_back(tag);
    end
  endtask

  task automatic push_now(input logic [W-1:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor / scoreboard
  always @(negedge character_clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_act = {left_btn, right_btn, jump_btn, left_press, right_press,
                 jump_press, jump_release, dbg_owner};
      n_vec++;
      if (mon_act !== mon_exp) begin
        n_err++;
        $display("FAIL %s t=%0t: got %b want %b (lb rb jb lp rp jp jr own)",
                 mon_tag, $time, mon_act, mon_exp);
      end
    end
  end

  // Stimulus
  initial begin
    sys_rst_n = 1'b0;
    raw_left  = 1'b0;
    raw_right = 1'b0;
    raw_jump  = 1'b0;
    tag = "reset_state";
    repeat (3) begin
      @(posedge character_clk);
      #1;
      push_now(ZV);
    end
    sys_rst_n = 1'b1;
    seg(3, 0, 0, 0, ZV);

    tag = "basic_press";
    seg(5, 1, 0, 0, ZV);
    seg(1, 1, 0, 0, LP);
    seg(10, 1, 0, 0, LH);
    tag = "basic_release";
    seg(5, 0, 0, 0, LH);
    seg(3, 0, 0, 0, ZV);

    tag = "glitch_3cyc";
    seg(3, 0, 0, 1, ZV);
    seg(8, 0, 0, 0, ZV);

    tag = "pulse_4cyc";
    seg(4, 0, 0, 1, ZV);
    seg(1, 0, 0, 0, ZV);
    seg(1, 0, 0, 0, JP);
    seg(3, 0, 0, 0, JH);
    seg(1, 0, 0, 0, ZV);
    seg(1, 0, 0, 0, JR);
    seg(3, 0, 0, 0, ZV);

    tag = "simultaneous";
    seg(5, 1, 1, 0, ZV);
    seg(1, 1, 1, 0, LP);
    seg(4, 1, 1, 0, LH);
    tag = "handover";
    seg(5, 0, 1, 0, LH);
    seg(1, 0, 1, 0, ZV);
    seg(1, 0, 1, 0, RP);
    seg(4, 0, 1, 0, RH);
    seg(5, 0, 0, 0, RH);
    seg(3, 0, 0, 0, ZV);

    tag = "charge_hold";
    seg(5, 0, 0, 1, ZV);
    seg(1, 0, 0, 1, JP);
    seg(194, 0, 0, 1, JH);
    seg(5, 0, 0, 0, JH);
    seg(1, 0, 0, 0, ZV);
    seg(1, 0, 0, 0, JR);
    seg(3, 0, 0, 0, ZV);

    tag = "reset_mid_op";
    seg(5, 1, 0, 0, ZV);
    seg(1, 1, 0, 0, LP);
    seg(4, 1, 1, 0, LH);
    raw_left  = 1'b1;
    raw_right = 1'b1;
    @(posedge character_clk);
    #1;
    sys_rst_n = 1'b0;
    raw_left  = 1'b0;
    #1;
    push_now(ZV);
    repeat (2) begin
      @(posedge character_clk);
      #1;
      push_now(ZV);
    end
    sys_rst_n = 1'b1;
    tag = "held_through_reset";
    seg(5, 0, 1, 0, ZV);
    seg(1, 0, 1, 0, RP);
    seg(3, 0, 1, 0, RH);
    seg(5, 0, 0, 0, RH);
    seg(3, 0, 0, 0, ZV);

    tag = "long_left_hold";
    seg(5, 1, 0, 0, ZV);
    seg(1, 1, 0, 0, LP);
    seg(15, 1, 0, 0, LH);
`ifdef BTN_AUTO_REPEAT_EN
    for (int k = 0; k < 3; k++) begin
      seg(1, 1, 0, 0, LG);
      seg(1, 1, 0, 0, LP);
      seg(2, 1, 0, 0, LH);
    end
    seg(1, 0, 0, 0, LG);
    seg(1, 0, 0, 0, LP);
    seg(2, 0, 0, 0, LH);
    seg(1, 0, 0, 0, LG);
    seg(1, 0, 0, 0, ZV);
`else
    seg(12, 1, 0, 0, LH);
    seg(5, 0, 0, 0, LH);
    seg(1, 0, 0, 0, ZV);
`endif
    seg(3, 0, 0, 0, ZV);

    // Report
    repeat (2) @(negedge character_clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending vectors want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
